// File: rtl/calendar_pkg.sv
// Shared calendar field widths, limits and date-validity helpers used by the
// wall-clock counter and the alarm block.
package calendar_pkg;

  localparam int SEC_W  = 6;
  localparam int MIN_W  = 6;
  localparam int HOUR_W = 5;
  localparam int DAY_W  = 5;
  localparam int MON_W  = 4;
  localparam int YEAR_W = 7;

  localparam int MAX_SEC  = 59;
  localparam int MAX_MIN  = 59;
  localparam int MAX_HOUR = 23;
  localparam int MAX_MON  = 12;
  localparam int MAX_YEAR = 99;

  typedef struct packed {
    logic [YEAR_W-1:0] year;
    logic [MON_W-1:0]  mon;
    logic [DAY_W-1:0]  day;
    logic [HOUR_W-1:0] hour;
    logic [MIN_W-1:0]  minute;
    logic [SEC_W-1:0]  second;
  } cal_t;

  // Returns 0 for an illegal month so any day check against it fails.
  function automatic logic [DAY_W-1:0] days_in_month(input logic [MON_W-1:0]  mon,
                                                     input logic [YEAR_W-1:0] year);
    case (mon)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: days_in_month = 5'd31;
      4'd4, 4'd6, 4'd9, 4'd11:                     days_in_month = 5'd30;
      4'd2:    days_in_month = (year[1:0] == 2'b00) ? 5'd29 : 5'd28;
      default: days_in_month = 5'd0;
    endcase
  endfunction

  // leap_phase shifts the leap-year pattern when the century base is not a multiple of 4.
  function automatic logic set_valid(input cal_t t, input logic [1:0] leap_phase);
    logic [YEAR_W-1:0] leap_year;
    leap_year = t.year + YEAR_W'(leap_phase);
    set_valid = (t.year   <= YEAR_W'(MAX_YEAR)) &&
                (t.mon    != '0) && (t.mon <= MON_W'(MAX_MON)) &&
                (t.day    != '0) && (t.day <= days_in_month(t.mon, leap_year)) &&
                (t.hour   <= HOUR_W'(MAX_HOUR)) &&
                (t.minute <= MIN_W'(MAX_MIN)) &&
                (t.second <= SEC_W'(MAX_SEC));
  endfunction

endpackage

// File: rtl/mod_counter.sv
// Zero-based modulo counter with synchronous load and a wrap carry that is
// valid in the same cycle as the increment request.
module mod_counter
  import calendar_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int MAX   = 59
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic [WIDTH-1:0] cnt_o,
  output logic             carry_o
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  assign carry_o = inc_i && (cnt_q == MAX_V);
  assign cnt_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (inc_i) begin
      cnt_d = carry_o ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/calendar_counter.sv
// Wall-clock calendar: second/minute/hour counters cascade into day, month and
// year with leap handling; a range-checked set port loads all fields atomically.
module calendar_counter
  import calendar_pkg::*;
#(
  parameter int YEAR_BASE = 2000,
  parameter int INIT_MON  = 1,
  parameter int INIT_DAY  = 1
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_ni,
  input  logic              s_f_i,
  input  logic              set_en_i,
  input  logic [YEAR_W-1:0] set_year_i,
  input  logic [MON_W-1:0]  set_mon_i,
  input  logic [DAY_W-1:0]  set_day_i,
  input  logic [HOUR_W-1:0] set_hour_i,
  input  logic [MIN_W-1:0]  set_min_i,
  input  logic [SEC_W-1:0]  set_sec_i,
  output logic              set_ack_o,
  output logic              set_err_o,
  output logic [SEC_W-1:0]  sec_o,
  output logic [MIN_W-1:0]  min_o,
  output logic [HOUR_W-1:0] hour_o,
  output logic [DAY_W-1:0]  day_o,
  output logic [MON_W-1:0]  mon_o,
  output logic [YEAR_W-1:0] year_o,
  output logic              min_f_o,
  output logic              hour_f_o,
  output logic              day_f_o
);

  localparam logic [1:0] LEAP_PHASE = 2'(YEAR_BASE % 4);

  cal_t set_val;
  logic set_ok, load, tick;
  logic sec_carry, min_carry, hour_carry;
  logic [DAY_W-1:0] dim;

  logic [DAY_W-1:0]  day_q,  day_d;
  logic [MON_W-1:0]  mon_q,  mon_d;
  logic [YEAR_W-1:0] year_q, year_d;
  logic min_f_q, hour_f_q, day_f_q, ack_q, err_q;

  assign set_val = {set_year_i, set_mon_i, set_day_i, set_hour_i, set_min_i, set_sec_i};
  assign set_ok  = set_valid(set_val, LEAP_PHASE);
  assign load    = set_en_i && set_ok;
  // A set request always wins over a coincident tick, even when the set is rejected.
  assign tick    = s_f_i && !set_en_i;

  mod_counter #(.WIDTH(SEC_W), .MAX(MAX_SEC)) u_sec (
    .clk_i      (sys_clk_i),
    .rst_ni     (sys_rst_ni),
    .inc_i      (tick),
    .load_i     (load),
    .load_val_i (set_sec_i),
    .cnt_o      (sec_o),
    .carry_o    (sec_carry)
  );

  mod_counter #(.WIDTH(MIN_W), .MAX(MAX_MIN)) u_min (
    .clk_i      (sys_clk_i),
    .rst_ni     (sys_rst_ni),
    .inc_i      (sec_carry),
    .load_i     (load),
    .load_val_i (set_min_i),
    .cnt_o      (min_o),
    .carry_o    (min_carry)
  );

  mod_counter #(.WIDTH(HOUR_W), .MAX(MAX_HOUR)) u_hour (
    .clk_i      (sys_clk_i),
    .rst_ni     (sys_rst_ni),
    .inc_i      (min_carry),
    .load_i     (load),
    .load_val_i (set_hour_i),
    .cnt_o      (hour_o),
    .carry_o    (hour_carry)
  );

  assign dim = days_in_month(mon_q, year_q + YEAR_W'(LEAP_PHASE));

  // Day and month are 1-based and the day limit tracks the current month/year.
  always_comb begin
    day_d  = day_q;
    mon_d  = mon_q;
    year_d = year_q;
    if (load) begin
      day_d  = set_day_i;
      mon_d  = set_mon_i;
      year_d = set_year_i;
    end else if (hour_carry) begin
      if (day_q == dim) begin
        day_d = 5'd1;
        if (mon_q == MON_W'(MAX_MON)) begin
          mon_d  = 4'd1;
          year_d = (year_q == YEAR_W'(MAX_YEAR)) ? '0 : year_q + 1'b1;
        end else begin
          mon_d = mon_q + 1'b1;
        end
      end else begin
        day_d = day_q + 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_ni) begin
    if (!sys_rst_ni) begin
      day_q    <= DAY_W'(INIT_DAY);
      mon_q    <= MON_W'(INIT_MON);
      year_q   <= '0;
      min_f_q  <= 1'b0;
      hour_f_q <= 1'b0;
      day_f_q  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      day_q    <= day_d;
      mon_q    <= mon_d;
      year_q   <= year_d;
      min_f_q  <= sec_carry;
      hour_f_q <= min_carry;
      day_f_q  <= hour_carry;
      ack_q    <= load;
      err_q    <= set_en_i && !set_ok;
    end
  end

  assign day_o     = day_q;
  assign mon_o     = mon_q;
  assign year_o    = year_q;
  assign min_f_o   = min_f_q;
  assign hour_f_o  = hour_f_q;
  assign day_f_o   = day_f_q;
  assign set_ack_o = ack_q;
  assign set_err_o = err_q;

endmodule

// File: tb/tb_calendar_counter.sv
// Scoreboard bench for calendar_counter: stimulus queues hand-computed results,
// a monitor compares them one edge later and checks pulses stay low otherwise.
module tb_calendar_counter;

  logic       clk;
  logic       rst_n;
  logic       s_f, set_en;
  logic [6:0] set_year;
  logic [3:0] set_mon;
  logic [4:0] set_day, set_hour;
  logic [5:0] set_min, set_sec;
  logic       set_ack, set_err, min_f, hour_f, day_f;
  logic [5:0] sec, mn;
  logic [4:0] hour, day;
  logic [3:0] mon;
  logic [6:0] year;

  typedef struct {
    string       nm;
    int          due;
    logic [32:0] st;
    logic [4:0]  p;
  } exp_t;

  localparam logic [4:0] P_NONE = 5'b00000;
  localparam logic [4:0] P_MIN  = 5'b10000;
  localparam logic [4:0] P_ALL3 = 5'b11100;
  localparam logic [4:0] P_ACK  = 5'b00010;
  localparam logic [4:0] P_ERR  = 5'b00001;

  exp_t sb[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   done = 1'b0;

  calendar_counter dut (
    .sys_clk_i  (clk),
    .sys_rst_ni (rst_n),
    .s_f_i      (s_f),
    .set_en_i   (set_en),
    .set_year_i (set_year),
    .set_mon_i  (set_mon),
    .set_day_i  (set_day),
    .set_hour_i (set_hour),
    .set_min_i  (set_min),
    .set_sec_i  (set_sec),
    .set_ack_o  (set_ack),
    .set_err_o  (set_err),
    .sec_o      (sec),
    .min_o      (mn),
    .hour_o     (hour),
    .day_o      (day),
    .mon_o      (mon),
    .year_o     (year),
    .min_f_o    (min_f),
    .hour_f_o   (hour_f),
    .day_f_o    (day_f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  task automatic drive(input string nm, input logic sf, input logic se,
                       input logic [6:0] sy, input logic [3:0] sm, input logic [4:0] sd,
                       input logic [4:0] sh, input logic [5:0] smi, input logic [5:0] ss,
                       input logic [6:0] ey, input logic [3:0] em, input logic [4:0] ed,
                       input logic [4:0] eh, input logic [5:0] emi, input logic [5:0] es,
                       input logic [4:0] ep);
    exp_t e;
    @(negedge clk);
    s_f = sf; set_en = se;
    set_year = sy; set_mon = sm; set_day = sd;
    set_hour = sh; set_min = smi; set_sec = ss;
    e.nm  = nm;
    e.due = cyc + 1;
    e.st  = {ey, em, ed, eh, emi, es};
    e.p   = ep;
    sb.push_back(e);
  endtask

  task automatic tick(input string nm, input logic [6:0] ey, input logic [3:0] em,
                      input logic [4:0] ed, input logic [4:0] eh, input logic [5:0] emi,
                      input logic [5:0] es, input logic [4:0] ep);
    drive(nm, 1'b1, 1'b0, 7'd0, 4'd0, 5'd0, 5'd0, 6'd0, 6'd0, ey, em, ed, eh, emi, es, ep);
  endtask

  task automatic setv(input string nm, input logic sf,
                      input logic [6:0] sy, input logic [3:0] sm, input logic [4:0] sd,
                      input logic [4:0] sh, input logic [5:0] smi, input logic [5:0] ss,
                      input logic [6:0] ey, input logic [3:0] em, input logic [4:0] ed,
                      input logic [4:0] eh, input logic [5:0] emi, input logic [5:0] es,
                      input logic [4:0] ep);
    drive(nm, sf, 1'b1, sy, sm, sd, sh, smi, ss, ey, em, ed, eh, emi, es, ep);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      s_f = 1'b0; set_en = 1'b0;
      set_year = '0; set_mon = '0; set_day = '0;
      set_hour = '0; set_min = '0; set_sec = '0;
    end
  endtask

  initial begin
    rst_n = 1'b1;
    s_f = 1'b0; set_en = 1'b0;
    set_year = '0; set_mon = '0; set_day = '0;
    set_hour = '0; set_min = '0; set_sec = '0;
    #3 rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int i = 1; i <= 60; i++)
      tick("tick60", 7'd0, 4'd1, 5'd1, 5'd0, 6'(i / 60), 6'(i % 60), (i == 60) ? P_MIN : P_NONE);
    idle(2);

    setv("set_nonleap", 1'b0, 7'd3, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59,
         7'd3, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59, P_ACK);
    tick("roll_nonleap", 7'd3, 4'd3, 5'd1, 5'd0, 6'd0, 6'd0, P_ALL3);
    idle(1);
    setv("set_leap", 1'b0, 7'd4, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59,
         7'd4, 4'd2, 5'd28, 5'd23, 6'd59, 6'd59, P_ACK);
    tick("roll_feb29", 7'd4, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0, P_ALL3);
    setv("set_feb29", 1'b0, 7'd4, 4'd2, 5'd29, 5'd23, 6'd59, 6'd59,
         7'd4, 4'd2, 5'd29, 5'd23, 6'd59, 6'd59, P_ACK);
    tick("roll_mar1", 7'd4, 4'd3, 5'd1, 5'd0, 6'd0, 6'd0, P_ALL3);
    setv("set_eoc", 1'b0, 7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59,
         7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, P_ACK);
    tick("roll_century", 7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ALL3);
    idle(1);

    setv("err_feb29_03", 1'b0, 7'd3, 4'd2, 5'd29, 5'd12, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_hour24", 1'b0, 7'd0, 4'd1, 5'd1, 5'd24, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_mon13", 1'b0, 7'd0, 4'd13, 5'd1, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_mon0", 1'b0, 7'd0, 4'd0, 5'd1, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_day0", 1'b0, 7'd0, 4'd1, 5'd0, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_min60", 1'b0, 7'd0, 4'd1, 5'd1, 5'd0, 6'd60, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_sec60", 1'b0, 7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd60,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_year100", 1'b0, 7'd100, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("err_apr31", 1'b0, 7'd5, 4'd4, 5'd31, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0, P_ERR);
    setv("set_feb29_00", 1'b0, 7'd0, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0,
         7'd0, 4'd2, 5'd29, 5'd0, 6'd0, 6'd0, P_ACK);
    setv("set_apr30", 1'b0, 7'd5, 4'd4, 5'd30, 5'd23, 6'd59, 6'd59,
         7'd5, 4'd4, 5'd30, 5'd23, 6'd59, 6'd59, P_ACK);
    tick("roll_may1", 7'd5, 4'd5, 5'd1, 5'd0, 6'd0, 6'd0, P_ALL3);

    setv("set_with_tick", 1'b1, 7'd10, 4'd6, 5'd30, 5'd23, 6'd59, 6'd59,
         7'd10, 4'd6, 5'd30, 5'd23, 6'd59, 6'd59, P_ACK);
    setv("err_with_tick", 1'b1, 7'd10, 4'd6, 5'd30, 5'd24, 6'd0, 6'd0,
         7'd10, 4'd6, 5'd30, 5'd23, 6'd59, 6'd59, P_ERR);
    tick("roll_jul1", 7'd10, 4'd7, 5'd1, 5'd0, 6'd0, 6'd0, P_ALL3);
    tick("tick_jul1", 7'd10, 4'd7, 5'd1, 5'd0, 6'd0, 6'd1, P_NONE);
    idle(1);

    setv("set_pre_rst", 1'b0, 7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59,
         7'd99, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, P_ACK);
    @(negedge clk);
    set_en = 1'b0; s_f = 1'b1;
    #2 rst_n = 1'b0;
    @(negedge clk);
    s_f = 1'b0;
    rst_n = 1'b1;
    idle(3);
    tick("tick_after_rst", 7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd1, P_NONE);
    idle(2);
    done = 1'b1;
  end

  // ---------------- monitor ----------------
  initial begin : monitor
    logic        prev_rst;
    logic [32:0] got_st;
    logic [4:0]  got_p;
    exp_t        e;
    prev_rst = 1'b1;
    forever begin
      @(posedge clk or negedge rst_n);
      #1;
      got_st = {year, mon, day, hour, mn, sec};
      got_p  = {min_f, hour_f, day_f, set_ack, set_err};
      if (prev_rst && !rst_n) begin
        n_cmp++;
        if (got_st !== {7'd0, 4'd1, 5'd1, 5'd0, 6'd0, 6'd0} || got_p !== P_NONE) begin
          n_bad++;
          $display("FAIL async_reset: got %0d-%0d-%0d %0d:%0d:%0d p=%b, required 0-1-1 0:0:0 p=00000",
                   year, mon, day, hour, mn, sec, got_p);
        end
      end else begin
        cyc++;
        while (sb.size() != 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          n_cmp++; n_bad++;
          $display("FAIL %s: got no check at cycle %0d, required check at cycle %0d", e.nm, cyc, e.due);
        end
        if (sb.size() != 0 && sb[0].due == cyc) begin
          e = sb.pop_front();
          n_cmp++;
          if (got_st !== e.st || got_p !== e.p) begin
            n_bad++;
            $display("FAIL %s: got %0d-%0d-%0d %0d:%0d:%0d p=%b, required %0d-%0d-%0d %0d:%0d:%0d p=%b",
                     e.nm, year, mon, day, hour, mn, sec, got_p,
                     e.st[32:26], e.st[25:22], e.st[21:17], e.st[16:12], e.st[11:6], e.st[5:0], e.p);
          end
        end else begin
          n_cmp++;
          if (got_p !== P_NONE) begin
            n_bad++;
            $display("FAIL idle_pulses: got p=%b at cycle %0d, required p=00000", got_p, cyc);
          end
        end
        if (done) begin
          n_cmp++;
          if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations, required 0", sb.size());
          end
          $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
          $finish;
        end
      end
      prev_rst = rst_n;
    end
  end

endmodule
